fofir_tap_sequencer: RTL and testbench
======================================

Name: fofir_tap_sequencer

Overview:
- Upstream feeder for the FoFIR 11-input tap mux inside the PE.
- Collects up to 11 tap words over a valid/ready load stream and holds them in a register bank that drives the mux data inputs.
- Then steps the 4-bit mux select through the active taps, one per cycle, with a downstream hold.
- Guarantees the mux never sees an unused select code (11..15) while its output is marked valid.

Parameters:
- data_width, 16, width of each tap word and of in_data.
- max_taps, 11, number of tap registers; fixed to 11, and the select width is fixed at 4.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  one-cycle request to begin a load+run job; honoured only in IDLE.
- tap_count  input  4  number of active taps, 1..11; sampled with start.
- in_valid  input  1  load word valid.
- in_data  input  data_width  load word.
- in_ready  output  1  block can accept a load word.
- hold  input  1  downstream stall; freezes sel during RUN.
- tap0..tap10  output  data_width each  tap register bank; drives mux in0..in10.
- sel  output  4  mux select.
- sel_valid  output  1  sel and the selected tap are meaningful this cycle.
- last  output  1  sel_valid cycle carries the final active tap.
- busy  output  1  state is not IDLE.
- done  output  1  one-cycle pulse at the end of a job.
- err  output  1  one-cycle pulse when start arrives with tap_count of 0 or greater than 11.

Behaviour:
- Reset (rst_n=0 at an edge) forces state to IDLE and clears every output register: tap0..tap10, sel, load counter and count register go to 0; in_ready, sel_valid, last, busy, done and err go to 0.
- Reset has priority over all other inputs and aborts a job in any state.
- The state machine has four states: IDLE, LOAD, RUN, DONE.
- IDLE:
  - in_ready=0 and sel_valid=0.
  - start with tap_count in 1..11: latch the count, clear all 11 tap registers to 0, set load_cnt=0, go to LOAD.
  - start with tap_count of 0 or 12..15: err=1 for the next cycle only; stay in IDLE; taps are untouched.
- LOAD:
  - in_ready=1.
  - Each cycle with in_valid=1 (and therefore in_valid&in_ready): write in_data to tap[load_cnt], then load_cnt+1.
  - The accept at load_cnt=count-1 moves to RUN with sel=0; in_ready drops in that same next cycle.
  - Cycles with in_valid=0 insert bubbles with no state change.
  - Taps at index count and above remain 0.
- RUN:
  - sel_valid=1.
  - last=1 exactly when sel==count-1.
  - hold=0: sel increments at the next edge.
  - hold=1: sel, sel_valid and last are frozen.
  - Leaving RUN happens on an edge where last=1 and hold=0; the next state is DONE.
  - Tap registers are stable throughout RUN.
  - in_ready=0 in RUN; in_valid is ignored.
- DONE: done=1 for one cycle, sel_valid=0, sel=0; then return to IDLE.
- sel is held at 0 whenever sel_valid=0, so sel never exceeds 10.
- busy=1 in LOAD, RUN and DONE.
- start asserted outside IDLE is ignored, with no err pulse.
- Latency:
  - start at edge t: in_ready=1 from t+1.
  - Final load accept at edge t: sel_valid=1, sel=0 from t+1.
  - With no hold: RUN lasts exactly count cycles, and done is asserted in the cycle after last.
- Single-tap job (count=1): exactly one RUN cycle, with sel=0 and last=1 in that cycle.
- Back-to-back jobs: start is accepted again on the first IDLE cycle after DONE. Taps keep their values until that next accepted start clears them.

Test Plan:
- Reset mid-RUN:
  - Load 11 words 0x0001..0x000B, reset at sel=5.
  - Required: next cycle all taps=0, sel=0, sel_valid=0, busy=0. A start one cycle later behaves normally.
- Full job:
  - tap_count=11, words 0x1000+k streamed without gaps, hold=0.
  - Required: in_ready high 11 cycles. Then sel walks 0..10 over 11 cycles with tapN=0x1000+N, last only at sel=10, then done pulses once.
- Partial job with bubbles and stall:
  - tap_count=4, in_valid toggling 1,0,1,1,0,1.
  - Required: taps 0..3 loaded in order and taps 4..10 = 0.
  - Then hold=1 for 3 cycles at sel=2: sel stays 2 with sel_valid=1, and the job completes at sel=3 with last=1.
- Bad count:
  - start with tap_count=0, then with tap_count=12.
  - Required: err pulses one cycle each, busy stays 0, in_ready stays 0.
- Single tap and ignored start:
  - tap_count=1, load 0xBEEF, and assert start again during RUN.
  - Required: one cycle with sel=0, last=1, tap0=0xBEEF, followed by done. The second start has no effect.

Source files
------------

// File: rtl/fofir_tap_sequencer.sv
// fofir_tap_sequencer
//   Upstream feeder for the FoFIR 11-input tap mux. A job starts with a
//   one-cycle start plus tap_count (1..11). The block then accepts tap_count
//   words over a load stream into a register bank that drives the mux data
//   inputs. After that it steps the 4-bit mux select through the active taps,
//   one per cycle, and honours a downstream hold.
//
// Handshake: a load word transfers on a rising edge where in_valid and
//   in_ready are both 1. in_ready is a registered output that is high only in
//   LOAD and does not depend on in_valid. in_valid may toggle freely; a cycle
//   without in_valid is a bubble.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   start, tap_count  job request and number of active taps (sampled in IDLE)
//   in_valid, in_data, in_ready   load stream
//   hold              downstream stall; freezes sel/sel_valid/last in RUN
//   tap0..tap10       tap register bank (mux in0..in10)
//   sel, sel_valid, last          mux select, qualifier, final-tap marker
//   busy, done, err   status: not idle, end-of-job pulse, bad-count pulse
//   dbg_state         current FSM state encoding (0 IDLE,1 LOAD,2 RUN,3 DONE)
module fofir_tap_sequencer #(
  parameter int data_width = 16,
  parameter int max_taps   = 11
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [3:0]            tap_count,
  input  logic                  in_valid,
  input  logic [data_width-1:0] in_data,
  output logic                  in_ready,
  input  logic                  hold,
  output logic [data_width-1:0] tap0,
  output logic [data_width-1:0] tap1,
  output logic [data_width-1:0] tap2,
  output logic [data_width-1:0] tap3,
  output logic [data_width-1:0] tap4,
  output logic [data_width-1:0] tap5,
  output logic [data_width-1:0] tap6,
  output logic [data_width-1:0] tap7,
  output logic [data_width-1:0] tap8,
  output logic [data_width-1:0] tap9,
  output logic [data_width-1:0] tap10,
  output logic [3:0]            sel,
  output logic                  sel_valid,
  output logic                  last,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                state;
  logic [3:0]            count;
  logic [3:0]            load_cnt;
  logic [data_width-1:0] taps [0:max_taps-1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      count     <= 4'd0;
      load_cnt  <= 4'd0;
      sel       <= 4'd0;
      sel_valid <= 1'b0;
      last      <= 1'b0;
      in_ready  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      for (int i = 0; i < max_taps; i++) taps[i] <= '0;
    end else begin
      // done and err are single-cycle pulses.
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (tap_count >= 4'd1 && tap_count <= 4'd11) begin
              count    <= tap_count;
              load_cnt <= 4'd0;
              for (int i = 0; i < max_taps; i++) taps[i] <= '0;
              in_ready <= 1'b1;
              busy     <= 1'b1;
              state    <= S_LOAD;
            end else begin
              err <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          if (in_valid) begin
            taps[load_cnt] <= in_data;
            load_cnt       <= load_cnt + 4'd1;
            if (load_cnt == count - 4'd1) begin
              in_ready  <= 1'b0;
              sel       <= 4'd0;
              sel_valid <= 1'b1;
              last      <= (count == 4'd1);
              state     <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (!hold) begin
            if (last) begin
              // sel returns to 0 together with sel_valid so the mux never
              // sees a stale or unused code.
              sel       <= 4'd0;
              sel_valid <= 1'b0;
              last      <= 1'b0;
              done      <= 1'b1;
              state     <= S_DONE;
            end else begin
              sel  <= sel + 4'd1;
              last <= ((sel + 4'd1) == (count - 4'd1));
            end
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign dbg_state = state;
  assign tap0  = taps[0];
  assign tap1  = taps[1];
  assign tap2  = taps[2];
  assign tap3  = taps[3];
  assign tap4  = taps[4];
  assign tap5  = taps[5];
  assign tap6  = taps[6];
  assign tap7  = taps[7];
  assign tap8  = taps[8];
  assign tap9  = taps[9];
  assign tap10 = taps[10];

endmodule

// File: tb/tb_fofir_tap_sequencer.sv
module tb_fofir_tap_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [3:0]  tap_count;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic        hold;
  logic [15:0] tap0, tap1, tap2, tap3, tap4, tap5, tap6, tap7, tap8, tap9, tap10;
  logic [3:0]  sel;
  logic        sel_valid;
  logic        last;
  logic        busy;
  logic        done;
  logic        err;
  logic [1:0]  dbg_state;
  logic [15:0] taps [0:10];

  int checks;
  int failures;

  fofir_tap_sequencer #(.data_width(16), .max_taps(11)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .tap_count(tap_count),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready), .hold(hold),
    .tap0(tap0), .tap1(tap1), .tap2(tap2), .tap3(tap3), .tap4(tap4),
    .tap5(tap5), .tap6(tap6), .tap7(tap7), .tap8(tap8), .tap9(tap9),
    .tap10(tap10), .sel(sel), .sel_valid(sel_valid), .last(last),
    .busy(busy), .done(done), .err(err), .dbg_state(dbg_state)
  );

  assign taps[0] = tap0;  assign taps[1] = tap1;  assign taps[2]  = tap2;
  assign taps[3] = tap3;  assign taps[4] = tap4;  assign taps[5]  = tap5;
  assign taps[6] = tap6;  assign taps[7] = tap7;  assign taps[8]  = tap8;
  assign taps[9] = tap9;  assign taps[10] = tap10;

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; inputs change and outputs are sampled 1 ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; tap_count = 4'd0; in_valid = 1'b0;
    in_data = 16'h0; hold = 1'b0;
    step(); step();
    checks++;
    if (sel !== 4'd0 || sel_valid !== 1'b0 || last !== 1'b0 || in_ready !== 1'b0 ||
        busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || dbg_state !== 2'd0) begin
      failures++;
      $display("FAIL reset_outputs sel=%0d sv=%b last=%b rdy=%b busy=%b done=%b err=%b st=%0d expected all 0",
               sel, sel_valid, last, in_ready, busy, done, err, dbg_state);
    end
    for (int i = 0; i < 11; i++) begin
      checks++;
      if (taps[i] !== 16'h0) begin
        failures++;
        $display("FAIL reset_tap%0d got=%h expected=0000", i, taps[i]);
      end
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_full_job();
    int rdy_cycles;
    rdy_cycles = 0;
    start = 1'b1; tap_count = 4'd11;
    step();
    start = 1'b0;
    for (int k = 0; k < 11; k++) begin
      in_valid = 1'b1;
      in_data  = 16'h1000 + 16'(k);
      if (in_ready === 1'b1) rdy_cycles++;
      step();
    end
    in_valid = 1'b0;
    checks++;
    if (rdy_cycles != 11 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL full_in_ready cycles=%0d now=%b expected 11 cycles then 0", rdy_cycles, in_ready);
    end
    for (int i = 0; i < 11; i++) begin
      checks++;
      if (taps[i] !== 16'h1000 + 16'(i)) begin
        failures++;
        $display("FAIL full_tap%0d got=%h expected=%h", i, taps[i], 16'h1000 + 16'(i));
      end
    end
    for (int n = 0; n < 11; n++) begin
      checks++;
      if (sel !== 4'(n) || sel_valid !== 1'b1 || last !== (n == 10) || done !== 1'b0) begin
        failures++;
        $display("FAIL full_run_%0d sel=%0d sv=%b last=%b done=%b expected sel=%0d sv=1 last=%b done=0",
                 n, sel, sel_valid, last, done, n, (n == 10));
      end
      step();
    end
    checks++;
    if (done !== 1'b1 || sel_valid !== 1'b0 || sel !== 4'd0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL full_done done=%b sv=%b sel=%0d busy=%b expected done=1 sv=0 sel=0 busy=1",
               done, sel_valid, sel, busy);
    end
    step();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL full_idle done=%b busy=%b expected 0 0", done, busy);
    end
  endtask

  task automatic test_partial_hold();
    logic [5:0] pat;
    int widx;
    pat  = 6'b101101; // bit i applies in load cycle i: 1,0,1,1,0,1
    widx = 0;
    start = 1'b1; tap_count = 4'd4;
    step();
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      in_valid = pat[i];
      in_data  = 16'h00A0 + 16'(widx);
      step();
      if (pat[i]) widx++;
    end
    in_valid = 1'b0;
    checks++;
    if (sel_valid !== 1'b1 || sel !== 4'd0 || last !== 1'b0) begin
      failures++;
      $display("FAIL partial_run_entry sv=%b sel=%0d last=%b expected sv=1 sel=0 last=0", sel_valid, sel, last);
    end
    for (int i = 0; i < 11; i++) begin
      checks++;
      if (taps[i] !== ((i < 4) ? 16'h00A0 + 16'(i) : 16'h0)) begin
        failures++;
        $display("FAIL partial_tap%0d got=%h expected=%h", i, taps[i],
                 (i < 4) ? 16'h00A0 + 16'(i) : 16'h0);
      end
    end
    step(); step();
    checks++;
    if (sel !== 4'd2) begin
      failures++;
      $display("FAIL partial_sel2 got=%0d expected=2", sel);
    end
    hold = 1'b1;
    for (int h = 0; h < 3; h++) begin
      step();
      checks++;
      if (sel !== 4'd2 || sel_valid !== 1'b1 || last !== 1'b0 || done !== 1'b0) begin
        failures++;
        $display("FAIL partial_hold_%0d sel=%0d sv=%b last=%b done=%b expected sel=2 sv=1 last=0 done=0",
                 h, sel, sel_valid, last, done);
      end
    end
    hold = 1'b0;
    step();
    checks++;
    if (sel !== 4'd3 || sel_valid !== 1'b1 || last !== 1'b1) begin
      failures++;
      $display("FAIL partial_last sel=%0d sv=%b last=%b expected sel=3 sv=1 last=1", sel, sel_valid, last);
    end
    step();
    checks++;
    if (done !== 1'b1 || sel_valid !== 1'b0) begin
      failures++;
      $display("FAIL partial_done done=%b sv=%b expected 1 0", done, sel_valid);
    end
    step();
  endtask

  task automatic test_bad_count();
    logic [3:0] bad [0:1];
    bad[0] = 4'd0; bad[1] = 4'd12;
    for (int b = 0; b < 2; b++) begin
      start = 1'b1; tap_count = bad[b];
      step();
      start = 1'b0;
      checks++;
      if (err !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL bad_count_%0d err=%b busy=%b rdy=%b expected err=1 busy=0 rdy=0",
                 bad[b], err, busy, in_ready);
      end
      step();
      checks++;
      if (err !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0 || tap0 !== 16'h00A0) begin
        failures++;
        $display("FAIL bad_count_after_%0d err=%b busy=%b rdy=%b tap0=%h expected 0 0 0 00a0",
                 bad[b], err, busy, in_ready, tap0);
      end
    end
  endtask

  task automatic test_single_ignored_start();
    start = 1'b1; tap_count = 4'd1;
    step();
    start = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || tap1 !== 16'h0) begin
      failures++;
      $display("FAIL single_load rdy=%b tap1=%h expected rdy=1 tap1=0000", in_ready, tap1);
    end
    in_valid = 1'b1; in_data = 16'hBEEF;
    step();
    in_valid = 1'b0;
    checks++;
    if (sel !== 4'd0 || sel_valid !== 1'b1 || last !== 1'b1 || tap0 !== 16'hBEEF || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL single_run sel=%0d sv=%b last=%b tap0=%h rdy=%b expected sel=0 sv=1 last=1 tap0=beef rdy=0",
               sel, sel_valid, last, tap0, in_ready);
    end
    start = 1'b1; tap_count = 4'd3;
    step();
    start = 1'b0;
    checks++;
    if (done !== 1'b1 || sel_valid !== 1'b0 || err !== 1'b0) begin
      failures++;
      $display("FAIL single_done done=%b sv=%b err=%b expected 1 0 0", done, sel_valid, err);
    end
    step(); step();
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0 || done !== 1'b0 || tap0 !== 16'hBEEF) begin
      failures++;
      $display("FAIL single_ignored_start busy=%b rdy=%b done=%b tap0=%h expected 0 0 0 beef",
               busy, in_ready, done, tap0);
    end
  endtask

  task automatic test_reset_mid_run();
    start = 1'b1; tap_count = 4'd11;
    step();
    start = 1'b0;
    for (int k = 0; k < 11; k++) begin
      in_valid = 1'b1;
      in_data  = 16'(k + 1);
      step();
    end
    in_valid = 1'b0;
    for (int n = 0; n < 5; n++) step();
    checks++;
    if (sel !== 4'd5 || sel_valid !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid_pre sel=%0d sv=%b expected 5 1", sel, sel_valid);
    end
    rst_n = 1'b0;
    step();
    checks++;
    if (sel !== 4'd0 || sel_valid !== 1'b0 || busy !== 1'b0 || last !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_ctrl sel=%0d sv=%b busy=%b last=%b expected all 0", sel, sel_valid, busy, last);
    end
    for (int i = 0; i < 11; i++) begin
      checks++;
      if (taps[i] !== 16'h0) begin
        failures++;
        $display("FAIL rst_mid_tap%0d got=%h expected=0000", i, taps[i]);
      end
    end
    rst_n = 1'b1;
    step();
    start = 1'b1; tap_count = 4'd2;
    step();
    start = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid_restart rdy=%b busy=%b expected 1 1", in_ready, busy);
    end
    in_valid = 1'b1; in_data = 16'h0055;
    step();
    in_data = 16'h0066;
    step();
    in_valid = 1'b0;
    checks++;
    if (sel !== 4'd0 || sel_valid !== 1'b1 || last !== 1'b0 || tap0 !== 16'h0055 || tap1 !== 16'h0066) begin
      failures++;
      $display("FAIL rst_mid_run0 sel=%0d sv=%b last=%b tap0=%h tap1=%h expected 0 1 0 0055 0066",
               sel, sel_valid, last, tap0, tap1);
    end
    step();
    checks++;
    if (sel !== 4'd1 || last !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid_run1 sel=%0d last=%b expected 1 1", sel, last);
    end
    step();
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid_done got=%b expected=1", done);
    end
    step();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_full_job();
    test_partial_hold();
    test_bad_count();
    test_single_ignored_start();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
